washer_key_conditioner: RTL and testbench
=========================================

Name: washer_key_conditioner

Overview:
- Front-panel input stage that sits directly upstream of the washer controller.
- Takes four raw, bouncy, asynchronous push-buttons and synchronises and debounces each one.
- Emits the washer's POWER level plus single-cycle STOP/SET_M/SET_W command pulses.
- Adds a long-press STOP detector that produces an emergency-off pulse and forces POWER low.

Parameters:
- DEB_CYCLES, 20: consecutive cycles a synchronised key must differ from its debounced state before the new level is accepted; legal range ≥2.
- LONG_CYCLES, 200: cycles the debounced STOP must stay high to raise LONG_STOP; must be > DEB_CYCLES.

Ports:
- CLK  in  1  system clock, rising-edge.
- RST  in  1  asynchronous, active-high reset.
- KEY_POWER  in  1  raw power button, active-high, asynchronous to CLK.
- KEY_STOP  in  1  raw stop/pause button, active-high.
- KEY_SET_M  in  1  raw mode-select button, active-high.
- KEY_SET_W  in  1  raw water-level button, active-high.
- POWER  out  1  registered power level, toggled by each debounced POWER press.
- STOP  out  1  one-cycle pulse per debounced STOP press.
- SET_M  out  1  one-cycle pulse per debounced SET_M press.
- SET_W  out  1  one-cycle pulse per debounced SET_W press.
- LONG_STOP  out  1  one-cycle pulse when STOP has been held LONG_CYCLES.
- KEY_STATE  out  4  debounced levels {SET_W, SET_M, STOP, POWER}.

Behaviour:
- Reset (async, RST=1): all synchroniser flops, debounce counters, KEY_STATE, POWER, STOP, SET_M, SET_W, LONG_STOP, and the hold counter go to 0 immediately. Outputs stay 0 while RST is high.
- Synchroniser: 2 flops per key. The raw level reaches sync2 after 2 edges.
- Debounce, per key, at each edge:
  - If sync2 == stable: counter <= 0.
  - Else if counter == DEB_CYCLES-1: stable <= sync2, counter <= 0.
  - Else: counter <= counter+1.
  - Counter width is $clog2(DEB_CYCLES).
- Press event: stable rises 0->1. The pulse output is registered and is high for exactly one cycle on the edge after stable rises.
- Latency: raw held high, first sampling edge = edge 0 → pulse high from edge DEB_CYCLES+2 to edge DEB_CYCLES+3. Release produces no pulse.
- Glitch rejection: any sync2 agreement with stable before the count completes clears the counter. A bounce shorter than DEB_CYCLES never changes stable.
- POWER: toggles on each POWER press event.
- Gating: STOP, SET_M, SET_W and LONG_STOP pulses are suppressed while the registered POWER is 0.
  - Gating uses the POWER value before any same-edge toggle.
  - A power-on press plus a SET_M press on the same edge gives no SET_M pulse.
  - A power-off press plus a SET_M press on the same edge does give the SET_M pulse.
- Long press, hold counter:
  - Counts while the debounced STOP is 1 and POWER is 1.
  - Clears when the debounced STOP is 0.
  - Saturates at LONG_CYCLES.
  - On the edge the counter reaches LONG_CYCLES, LONG_STOP pulses once and POWER is cleared to 0 on that same edge.
  - Clearing has priority over a simultaneous POWER toggle.
  - No further LONG_STOP until STOP is released and pressed again.
- A short STOP press always emits STOP at press time. A long press emits STOP at press, then LONG_STOP later.
- Multiple keys are independent: simultaneous presses on different keys all pulse on the same edge, subject to gating.
- A key held through reset deassertion: stable starts at 0, so a press event occurs DEB_CYCLES+3 edges after RST falls.
- No combinational path from the KEY_* inputs to any output.

Test Plan:
Bench settings: DEB_CYCLES=4, LONG_CYCLES=16.
1. Reset then idle: RST high 3 cycles, keys 0 → all outputs and KEY_STATE = 0 throughout.
2. Clean POWER press: KEY_POWER high from edge 0 for 10 cycles → KEY_STATE[0] rises at edge 5, POWER = 1 from edge 6. Second identical press → POWER returns to 0.
3. Bounce rejection, POWER=1: KEY_SET_M toggles 1,0,1,0 every 2 cycles, then 0 → SET_M never pulses. A clean 8-cycle press → exactly one SET_M pulse, high for 1 cycle at edge 6.
4. Gating: POWER=0, press SET_W and STOP → no pulses. Press POWER and SET_W on the same edge → POWER becomes 1, no SET_W pulse.
5. Long STOP, POWER=1: hold KEY_STOP 40 cycles → STOP pulse at edge 6. LONG_STOP pulse 16 edges after KEY_STATE[1] rises, POWER = 0 on that edge. No second LONG_STOP while still held.
6. Reset mid-debounce: KEY_SET_M high, assert RST at edge 3 for 2 cycles, keep the key held → no pulse during reset. With POWER re-enabled, the SET_M press event occurs 7 edges after RST deasserts.

Source files
------------

// File: rtl/washer_key_conditioner.sv
// Front-panel key conditioner: synchronises and debounces four raw push-buttons and
// turns them into the washer's POWER level, gated command pulses and a long-press STOP.

module washer_key_debounce #(
    parameter int DEB_CYCLES = 20
) (
    input  logic CLK,
    input  logic RST,
    input  logic key_raw,
    output logic key_stable
);
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // NOTE: every register uses non-blocking assignment so all flops sample the same pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

    // Any cycle where the synchronised key agrees with the accepted level restarts the count.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt        <= '0;
            key_stable <= 1'b0;
        end else if (sync2 == key_stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            key_stable <= sync2;
            cnt        <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

module washer_key_conditioner #(
    parameter int DEB_CYCLES  = 20,
    parameter int LONG_CYCLES = 200
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       KEY_POWER,
    input  logic       KEY_STOP,
    input  logic       KEY_SET_M,
    input  logic       KEY_SET_W,
    output logic       POWER,
    output logic       STOP,
    output logic       SET_M,
    output logic       SET_W,
    output logic       LONG_STOP,
    output logic [3:0] KEY_STATE
);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

    logic [3:0]    key_raw;
    logic [3:0]    stable;
    logic [3:0]    stable_d;
    logic [3:0]    press;
    logic [HW-1:0] hold_cnt;
    logic          long_hit;

    assign key_raw = {KEY_SET_W, KEY_SET_M, KEY_STOP, KEY_POWER};

    for (genvar k = 0; k < 4; k++) begin : g_key
        washer_key_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .CLK       (CLK),
            .RST       (RST),
            .key_raw   (key_raw[k]),
            .key_stable(stable[k])
        );
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stable_d <= '0;
        end else begin
            stable_d <= stable;
        end
    end

    assign press     = stable & ~stable_d;
    assign KEY_STATE = stable;

    // Hold counter only advances while powered, so an emergency-off fires at most once per press.
    assign long_hit = stable[1] && POWER && (hold_cnt == HOLD_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold_cnt <= '0;
        end else if (!stable[1]) begin
            hold_cnt <= '0;
        end else if (POWER && (hold_cnt != HOLD_MAX)) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    // Gating reads POWER before this edge's toggle; emergency-off wins over a POWER press.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            POWER     <= 1'b0;
            STOP      <= 1'b0;
            SET_M     <= 1'b0;
            SET_W     <= 1'b0;
            LONG_STOP <= 1'b0;
        end else begin
            STOP      <= press[1] & POWER;
            SET_M     <= press[2] & POWER;
            SET_W     <= press[3] & POWER;
            LONG_STOP <= long_hit;
            if (long_hit) begin
                POWER <= 1'b0;
            end else if (press[0]) begin
                POWER <= ~POWER;
            end
        end
    end
endmodule

// File: tb/tb_washer_key_conditioner.sv
// Bench for washer_key_conditioner: directed scenarios with literal timing expectations,
// then random bouncy keys and resets, all outputs compared every cycle to a window-based model.

module tb_washer_key_conditioner;
    localparam int DEB  = 4;
    localparam int LONG = 16;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       KEY_POWER = 1'b0;
    logic       KEY_STOP  = 1'b0;
    logic       KEY_SET_M = 1'b0;
    logic       KEY_SET_W = 1'b0;
    logic       POWER, STOP, SET_M, SET_W, LONG_STOP;
    logic [3:0] KEY_STATE;

    int checks = 0;
    int errors = 0;
    int n_stop = 0, n_setm = 0, n_setw = 0, n_long = 0;

    always #5 CLK = ~CLK;

    washer_key_conditioner #(
        .DEB_CYCLES (DEB),
        .LONG_CYCLES(LONG)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .KEY_POWER(KEY_POWER),
        .KEY_STOP (KEY_STOP),
        .KEY_SET_M(KEY_SET_M),
        .KEY_SET_W(KEY_SET_W),
        .POWER    (POWER),
        .STOP     (STOP),
        .SET_M    (SET_M),
        .SET_W    (SET_W),
        .LONG_STOP(LONG_STOP),
        .KEY_STATE(KEY_STATE)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a key's accepted level flips once the last DEB synchronised samples
    // (raw samples 2..DEB+1 edges old) all disagree with it.
    logic [3:0] raw_hist [0:DEB+1];
    logic [3:0] m_stable = '0, m_rose = '0, new_stable;
    logic       m_power = 0, m_stop = 0, m_setm = 0, m_setw = 0, m_long = 0;
    logic       old_power, fire, all_diff;
    int         m_hold = 0;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int j = 0; j <= DEB + 1; j++) raw_hist[j] = '0;
            m_stable = '0; m_rose = '0; m_hold = 0;
            m_power = 0; m_stop = 0; m_setm = 0; m_setw = 0; m_long = 0;
        end else begin
            old_power = m_power;
            fire = 1'b0;
            if (!m_stable[1]) m_hold = 0;
            else if (old_power && m_hold < LONG) begin
                m_hold++;
                fire = (m_hold == LONG);
            end
            m_stop = m_rose[1] & old_power;
            m_setm = m_rose[2] & old_power;
            m_setw = m_rose[3] & old_power;
            m_long = fire;
            if (fire) m_power = 1'b0;
            else if (m_rose[0]) m_power = ~old_power;
            for (int j = DEB + 1; j > 0; j--) raw_hist[j] = raw_hist[j-1];
            raw_hist[0] = {KEY_SET_W, KEY_SET_M, KEY_STOP, KEY_POWER};
            for (int k = 0; k < 4; k++) begin
                all_diff = 1'b1;
                for (int j = 2; j <= DEB + 1; j++)
                    if (raw_hist[j][k] == m_stable[k]) all_diff = 1'b0;
                new_stable[k] = all_diff ? ~m_stable[k] : m_stable[k];
            end
            m_rose   = new_stable & ~m_stable;
            m_stable = new_stable;
        end
    end

    always @(negedge CLK) begin
        check("POWER", 32'(POWER), 32'(m_power));
        check("STOP", 32'(STOP), 32'(m_stop));
        check("SET_M", 32'(SET_M), 32'(m_setm));
        check("SET_W", 32'(SET_W), 32'(m_setw));
        check("LONG_STOP", 32'(LONG_STOP), 32'(m_long));
        check("KEY_STATE", 32'(KEY_STATE), 32'(m_stable));
        n_stop += int'(STOP);
        n_setm += int'(SET_M);
        n_setw += int'(SET_W);
        n_long += int'(LONG_STOP);
    end

    task automatic go_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_edges(input int n);
        repeat (n) go_edge();
    endtask

    task automatic set_key(input int idx, input logic v);
        case (idx)
            0: KEY_POWER = v;
            1: KEY_STOP  = v;
            2: KEY_SET_M = v;
            default: KEY_SET_W = v;
        endcase
    endtask

    task automatic press(input int idx, input int cycles);
        @(negedge CLK);
        set_key(idx, 1'b1);
        run_edges(cycles);
        set_key(idx, 1'b0);
        run_edges(DEB + 4);
    endtask

    int base, base2, ks_edge, stop_edge, long_edge, long_cnt, rst_left;
    logic pwr_at_long;
    logic [3:0] lvl;
    int rem [4];

    initial begin
        // 1: reset then idle
        for (int i = 0; i < 3; i++) begin
            go_edge();
            check("t1_reset_outs", 32'({POWER, STOP, SET_M, SET_W, LONG_STOP, KEY_STATE}), 32'd0);
        end
        @(negedge CLK);
        RST = 1'b0;
        run_edges(5);
        check("t1_idle_outs", 32'({POWER, STOP, SET_M, SET_W, LONG_STOP, KEY_STATE}), 32'd0);

        // 2: clean POWER press timing, then toggle off and on again
        @(negedge CLK);
        KEY_POWER = 1'b1;
        run_edges(5);
        check("t2_ks0_e4", 32'(KEY_STATE[0]), 32'd0);
        run_edges(1);
        check("t2_ks0_e5", 32'(KEY_STATE[0]), 32'd1);
        check("t2_pwr_e5", 32'(POWER), 32'd0);
        run_edges(1);
        check("t2_pwr_e6", 32'(POWER), 32'd1);
        run_edges(3);
        KEY_POWER = 1'b0;
        run_edges(DEB + 4);
        press(0, 10);
        check("t2_pwr_off", 32'(POWER), 32'd0);
        press(0, 10);
        check("t2_pwr_on", 32'(POWER), 32'd1);

        // 3: bounce rejection, then one clean SET_M press
        base = n_setm;
        @(negedge CLK);
        KEY_SET_M = 1'b1; run_edges(2);
        KEY_SET_M = 1'b0; run_edges(2);
        KEY_SET_M = 1'b1; run_edges(2);
        KEY_SET_M = 1'b0; run_edges(DEB + 6);
        check("t3_bounce_pulses", 32'(n_setm - base), 32'd0);
        check("t3_bounce_ks2", 32'(KEY_STATE[2]), 32'd0);
        base = n_setm;
        @(negedge CLK);
        KEY_SET_M = 1'b1;
        run_edges(6);
        check("t3_setm_e5", 32'(SET_M), 32'd0);
        run_edges(1);
        check("t3_setm_e6", 32'(SET_M), 32'd1);
        run_edges(1);
        check("t3_setm_e7", 32'(SET_M), 32'd0);
        KEY_SET_M = 1'b0;
        run_edges(DEB + 4);
        check("t3_setm_count", 32'(n_setm - base), 32'd1);

        // 4: gating while powered off, and power-on with simultaneous SET_W
        press(0, 10);
        check("t4_pwr_off", 32'(POWER), 32'd0);
        base = n_setw; base2 = n_stop;
        @(negedge CLK);
        KEY_SET_W = 1'b1; KEY_STOP = 1'b1;
        run_edges(10);
        KEY_SET_W = 1'b0; KEY_STOP = 1'b0;
        run_edges(DEB + 4);
        check("t4_gated_pulses", 32'((n_setw - base) + (n_stop - base2)), 32'd0);
        base = n_setw;
        @(negedge CLK);
        KEY_SET_W = 1'b1; KEY_POWER = 1'b1;
        run_edges(10);
        KEY_SET_W = 1'b0; KEY_POWER = 1'b0;
        run_edges(DEB + 4);
        check("t4_same_edge_setw", 32'(n_setw - base), 32'd0);
        check("t4_pwr_on", 32'(POWER), 32'd1);

        // 5: long STOP hold
        ks_edge = -1; stop_edge = -1; long_edge = -1; long_cnt = 0; pwr_at_long = 1'b1;
        @(negedge CLK);
        KEY_STOP = 1'b1;
        for (int e = 0; e < 40; e++) begin
            go_edge();
            if (KEY_STATE[1] && ks_edge < 0) ks_edge = e;
            if (STOP && stop_edge < 0) stop_edge = e;
            if (LONG_STOP) begin
                long_cnt++;
                if (long_edge < 0) begin
                    long_edge = e;
                    pwr_at_long = POWER;
                end
            end
        end
        KEY_STOP = 1'b0;
        run_edges(DEB + 4);
        check("t5_ks1_edge", 32'(ks_edge), 32'd5);
        check("t5_stop_edge", 32'(stop_edge), 32'd6);
        check("t5_long_edge", 32'(long_edge), 32'd21);
        check("t5_long_count", 32'(long_cnt), 32'd1);
        check("t5_pwr_at_long", 32'(pwr_at_long), 32'd0);

        // 6: reset mid-debounce with SET_M and POWER held through it
        base = n_setm;
        @(negedge CLK);
        KEY_SET_M = 1'b1; KEY_POWER = 1'b1;
        run_edges(3);
        RST = 1'b1;
        run_edges(1);
        check("t6_in_reset", 32'({POWER, STOP, SET_M, SET_W, LONG_STOP, KEY_STATE}), 32'd0);
        run_edges(1);
        check("t6_in_reset2", 32'({POWER, STOP, SET_M, SET_W, LONG_STOP, KEY_STATE}), 32'd0);
        RST = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            go_edge();
            if (k == 5) check("t6_ks2_k5", 32'(KEY_STATE[2]), 32'd0);
            if (k == 6) begin
                check("t6_ks2_k6", 32'(KEY_STATE[2]), 32'd1);
                check("t6_pwr_k6", 32'(POWER), 32'd0);
            end
            if (k == 7) check("t6_pwr_k7", 32'(POWER), 32'd1);
        end
        check("t6_setm_gated", 32'(n_setm - base), 32'd0);
        KEY_SET_M = 1'b0; KEY_POWER = 1'b0;
        run_edges(DEB + 4);

        // Random bouncy keys with occasional asynchronous resets
        lvl = '0; rst_left = 0;
        for (int k = 0; k < 4; k++) rem[k] = 0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge CLK);
            for (int k = 0; k < 4; k++) begin
                if (rem[k] == 0) begin
                    lvl[k] = ~lvl[k];
                    rem[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                        : $urandom_range(4, (k == 1) ? 40 : 12);
                end else begin
                    rem[k]--;
                end
            end
            {KEY_SET_W, KEY_SET_M, KEY_STOP, KEY_POWER} = lvl;
            #2;
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) RST = 1'b0;
            end else if ($urandom_range(0, 799) == 0) begin
                RST = 1'b1;
                rst_left = $urandom_range(1, 3);
            end
        end
        @(negedge CLK);
        RST = 1'b0;
        KEY_POWER = 1'b0; KEY_STOP = 1'b0; KEY_SET_M = 1'b0; KEY_SET_W = 1'b0;
        run_edges(DEB + 4);
        @(negedge CLK);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
